// File: rtl/cci_mpf_csr_event_counters.sv
// Per-event accumulators for the MPF CSR manager: staged event sampling, indexed
// read with one-cycle latency, and single/all clear. Define CCI_MPF_CSR_EVENT_SATURATE_EN
// to make counters stick at all-ones instead of wrapping.
module cci_mpf_csr_event_counters #(
  parameter int N_EVENTS  = 6,
  parameter int CNT_WIDTH = 64,
  parameter int IDX_WIDTH = $clog2(N_EVENTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_EVENTS-1:0]  in_events,
  input  logic                 rd_req,
  input  logic [IDX_WIDTH-1:0] rd_idx,
  output logic                 rd_rsp_valid,
  output logic [CNT_WIDTH-1:0] rd_rsp_data,
  input  logic                 clr_req,
  input  logic                 clr_all,
  input  logic [IDX_WIDTH-1:0] clr_idx
);

  logic [N_EVENTS-1:0]  ev_q;
  logic [N_EVENTS-1:0]  clr_hit;
  logic [CNT_WIDTH-1:0] cnt_view [N_EVENTS];
  logic [CNT_WIDTH-1:0] rd_mux;

  always_ff @(posedge clk) begin
    if (reset) ev_q <= '0;
    else       ev_q <= in_events;
  end

  // An out-of-range clr_idx matches no counter, so the clear is dropped.
  always_comb begin
    clr_hit = '0;
    for (int i = 0; i < N_EVENTS; i++)
      clr_hit[i] = clr_req && (clr_all || (clr_idx == IDX_WIDTH'(i)));
  end

  for (genvar i = 0; i < N_EVENTS; i++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [CNT_WIDTH-1:0] ev_ext;
    logic [CNT_WIDTH-1:0] cnt_inc;

    assign ev_ext = {{(CNT_WIDTH-1){1'b0}}, ev_q[i]};
`ifdef CCI_MPF_CSR_EVENT_SATURATE_EN
    assign cnt_inc = (&cnt_r) ? cnt_r : cnt_r + ev_ext;
`else
    assign cnt_inc = cnt_r + ev_ext;
`endif

    // A clear keeps the staged event so nothing sampled that cycle is lost.
    always_ff @(posedge clk) begin
      if (reset)           cnt_r <= '0;
      else if (clr_hit[i]) cnt_r <= ev_ext;
      else                 cnt_r <= cnt_inc;
    end

    assign cnt_view[i] = cnt_r;
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_EVENTS; i++)
      if (rd_idx == IDX_WIDTH'(i)) rd_mux = cnt_view[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_rsp_valid <= 1'b0;
      rd_rsp_data  <= '0;
    end else begin
      rd_rsp_valid <= rd_req;
      if (rd_req) rd_rsp_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_cci_mpf_csr_event_counters.sv
// Scoreboard bench for cci_mpf_csr_event_counters: a per-cycle event-count model
// queues expected read responses; a negedge monitor checks data and latency.
module tb_cci_mpf_csr_event_counters;
  localparam int N  = 6;
  localparam int CW = 64;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  in_events;
  logic          rd_req;
  logic [IW-1:0] rd_idx;
  logic          rd_rsp_valid;
  logic [CW-1:0] rd_rsp_data;
  logic          clr_req;
  logic          clr_all;
  logic [IW-1:0] clr_idx;

  cci_mpf_csr_event_counters #(.N_EVENTS(N), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .in_events(in_events),
    .rd_req(rd_req), .rd_idx(rd_idx),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .clr_req(clr_req), .clr_all(clr_all), .clr_idx(clr_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] data;
    int            due;
    int            idx;
  } exp_t;

  exp_t          q[$];
  logic [CW-1:0] m_cnt [N];
  logic [N-1:0]  m_stage;
  int            cyc = 0;
  int            n_vec = 0;
  int            n_miss = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model of what the upcoming edge does: events seen now are counted one edge later.
  task automatic step();
    exp_t e;
    int   ri;
    int   ci;
    if (reset) begin
      for (int i = 0; i < N; i++) m_cnt[i] = '0;
      m_stage = '0;
      return;
    end
    ri = int'(rd_idx);
    ci = int'(clr_idx);
    if (rd_req) begin
      e.data = (ri < N) ? m_cnt[ri] : '0;
      e.due  = cyc + 1;
      e.idx  = ri;
      q.push_back(e);
    end
    for (int i = 0; i < N; i++) begin
      if (clr_req && (clr_all || ci == i)) m_cnt[i] = {{(CW-1){1'b0}}, m_stage[i]};
      else if (m_stage[i]) begin
`ifdef CCI_MPF_CSR_EVENT_SATURATE_EN
        if (m_cnt[i] != {CW{1'b1}}) m_cnt[i] = m_cnt[i] + 1'b1;
`else
        m_cnt[i] = m_cnt[i] + 1'b1;
`endif
      end
    end
    m_stage = in_events;
  endtask

  task automatic drive(input logic [N-1:0] ev, input logic rr, input logic [IW-1:0] ri,
                       input logic cr, input logic ca, input logic [IW-1:0] ci,
                       input logic rs);
    @(negedge clk);
    in_events = ev;
    rd_req    = rr;
    rd_idx    = ri;
    clr_req   = cr;
    clr_all   = ca;
    clr_idx   = ci;
    reset     = rs;
    step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive('0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic read_all();
    for (int k = 0; k < N; k++) drive('0, 1'b1, IW'(k), 1'b0, 1'b0, '0, 1'b0);
    idle(2);
  endtask

  task automatic check_idle_outputs(input string tag);
    n_vec++;
    if (rd_rsp_valid !== 1'b0 || rd_rsp_data !== '0) begin
      n_miss++;
      $display("FAIL %s valid=%b data=%h want valid=0 data=0", tag, rd_rsp_valid, rd_rsp_data);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rd_rsp_valid === 1'b1) begin
      n_vec++;
      if (q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_rsp cyc=%0d data=%h want no response", cyc, rd_rsp_data);
      end else begin
        e = q.pop_front();
        if (e.due != cyc || rd_rsp_data !== e.data) begin
          n_miss++;
          $display("FAIL rd_rsp idx=%0d cyc=%0d data=%h want cyc=%0d data=%h",
                   e.idx, cyc, rd_rsp_data, e.due, e.data);
        end
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      n_vec++;
      n_miss++;
      $display("FAIL missing_rsp idx=%0d cyc=%0d valid=%b want valid=1 data=%h",
               e.idx, cyc, rd_rsp_valid, e.data);
    end
  end

  initial begin
    in_events = '0; rd_req = 1'b0; rd_idx = '0;
    clr_req = 1'b0; clr_all = 1'b0; clr_idx = '0; reset = 1'b1;
    for (int i = 0; i < N; i++) m_cnt[i] = '0;
    m_stage = '0;

    for (int k = 0; k < 3; k++) drive('0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    idle(1);
    check_idle_outputs("reset_outputs");

    // Event 0 held for ten cycles.
    for (int k = 0; k < 10; k++) drive(6'b000001, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    idle(2);
    read_all();

    // Three pulses on every event after a clear-all, then back-to-back reads.
    drive('0, 1'b0, '0, 1'b1, 1'b1, '0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(6'b111111, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      idle(1);
    end
    idle(1);
    read_all();

    // Clear of counter 2 while its event is held high.
    for (int k = 0; k < 4; k++) drive(6'b000100, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    drive(6'b000100, 1'b0, '0, 1'b1, 1'b0, 3'd2, 1'b0);
    drive(6'b000100, 1'b1, 3'd2, 1'b0, 1'b0, '0, 1'b0);
    drive(6'b000100, 1'b1, 3'd1, 1'b0, 1'b0, '0, 1'b0);
    idle(2);
    read_all();

    // Preload counter 4 near the top, then three events.
    idle(2);
    force dut.g_cnt[4].cnt_r = 64'hFFFF_FFFF_FFFF_FFFE;
    m_cnt[4] = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release dut.g_cnt[4].cnt_r;
    for (int k = 0; k < 3; k++) drive(6'b010000, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    idle(2);
    drive('0, 1'b1, 3'd4, 1'b0, 1'b0, '0, 1'b0);
    idle(2);

    // Out-of-range read and clear.
    for (int k = 0; k < 2; k++) drive(6'b111111, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    idle(2);
    drive('0, 1'b1, 3'd7, 1'b0, 1'b0, '0, 1'b0);
    drive('0, 1'b0, '0, 1'b1, 1'b0, 3'd6, 1'b0);
    drive('0, 1'b1, 3'd6, 1'b1, 1'b0, 3'd7, 1'b0);
    idle(2);
    read_all();

    // Read and clear of the same index in one cycle returns the pre-clear value.
    drive(6'b001000, 1'b1, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0);
    drive(6'b001000, 1'b1, 3'd3, 1'b1, 1'b1, 3'd0, 1'b0);
    idle(2);
    read_all();

    for (int k = 0; k < 400; k++)
      drive(N'($urandom), 1'($urandom_range(0, 1)), IW'($urandom_range(0, 7)),
            ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
            IW'($urandom_range(0, 7)), 1'b0);
    idle(2);
    read_all();

    // Reset in the middle of a busy stream with a read pending.
    for (int k = 0; k < 5; k++)
      drive(N'($urandom), 1'b1, IW'($urandom_range(0, 5)), 1'b0, 1'b0, '0, 1'b0);
    drive(6'b111111, 1'b1, 3'd1, 1'b1, 1'b0, 3'd2, 1'b1);
    idle(1);
    check_idle_outputs("post_reset_outputs");
    idle(1);
    read_all();

    idle(3);
    n_vec++;
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL drain outstanding=%0d want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cci_mpf_csr_event_counters.md
# cci_mpf_csr_event_counters

Event accumulator for the MPF CSR manager. It consumes the single-cycle event wires that the VTP and VC MAP shims drive through the CSR events modport, and sums each one into a 64-bit counter. It serves indexed counter reads and clears to the CSR read/write module, which forwards the values to the host over MMIO. One instance sits beside the CSR manager; the shims never see it.

## Interface
Parameters:
- N_EVENTS, 6: number of event inputs and counters.
- CNT_WIDTH, 64: counter width in bits.
- IDX_WIDTH, $clog2(N_EVENTS): width of the read and clear index.

Ports:
- clk  in  1  CCI clock; the only clock.
- reset  in  1  synchronous, active-high.
- in_events  in  N_EVENTS  level-sampled event wires. Each cycle high counts once. Bit mapping:
  - 0 vtp_out_event_4kb_hit
  - 1 4kb_miss
  - 2 2mb_hit
  - 3 2mb_miss
  - 4 pt_walk_busy
  - 5 vc_map_out_event_mapping_changed
- rd_req  in  1  read request strobe.
- rd_idx  in  IDX_WIDTH  counter to read.
- rd_rsp_valid  out  1  read response strobe.
- rd_rsp_data  out  CNT_WIDTH  counter value.
- clr_req  in  1  clear request strobe.
- clr_all  in  1  when set with clr_req, clear every counter.
- clr_idx  in  IDX_WIDTH  counter to clear when clr_all=0.

## Operation
- Stage 0: register in_events into ev_q on every cycle. ev_q resets to 0.
- Stage 1: each counter i updates from ev_q[i]:
  - Normal: cnt[i] <= cnt[i] + ev_q[i], modulo 2^CNT_WIDTH unless saturation is compiled in.
  - Targeted by a clear in the same cycle: cnt[i] <= ev_q[i]. The clear wins over the old value, but the staged event is kept, so no event is lost.
- clr_req with clr_all=1 targets all counters. With clr_all=0 it targets only cnt[clr_idx]. If clr_idx >= N_EVENTS, the clear has no effect.
- Reads:
  - rd_req is registered, so rd_rsp_valid is high exactly one cycle after each rd_req cycle.
  - rd_rsp_data carries cnt[rd_idx] as held during the request cycle, i.e. before that cycle's update.
  - rd_idx >= N_EVENTS returns 0.
  - rd_req may assert on consecutive cycles; each request gets its own response, in order. There is no backpressure.
- Read and clear in the same cycle on the same index: the response returns the pre-clear value.
- Reset mid-operation: all counters, ev_q, rd_rsp_valid and rd_rsp_data go to 0 on the next edge. Events and requests present in the reset cycle are discarded.

## Timing
- Reset values: rd_rsp_valid=0, rd_rsp_data=0, all counters 0, ev_q=0.
- Event at in_events in cycle t: visible in cnt from cycle t+2. A read issued in cycle t+2 returns it in cycle t+3.
- Read latency: 1 cycle, fixed.
- Clear issued in cycle t: counter equals ev_q[i] from cycle t+1.
- No combinational path from any input to any output.
- The 64-bit adders are single-cycle at the CCI clock target. Each adder adds at most 1 per cycle.

## Configuration
- CCI_MPF_CSR_EVENT_SATURATE_EN defined: counters saturate at all-ones. An increment at 2^CNT_WIDTH-1 leaves the value unchanged. A clear still sets the counter to ev_q[i].
- Macro undefined: counters wrap from 2^CNT_WIDTH-1 to 0.
- Nothing else depends on the macro.

## Test plan
- Reset, then hold in_events=6'b000001 for 10 cycles, then 0. A read of idx 0 returns 10; reads of idx 1–5 return 0. Each rd_rsp_valid arrives exactly one cycle after its rd_req.
- Pulse all six events on 3 separate cycles, then issue back-to-back reads of idx 0..5 on 6 consecutive cycles. Expect six consecutive responses, each equal to 3, in index order.
- Hold event 2 high continuously. Issue clr_req with clr_all=0, clr_idx=2 in cycle t. The counter reads 1 in cycle t+1 (staged event kept). Other counters are unaffected.
- Force cnt[4] to 2^64-2 with a backdoor, then apply 3 events:
  - Macro defined: reads 2^64-1.
  - Macro undefined: reads 1.
- Read with rd_idx=7 returns 0 with rd_rsp_valid=1. Clear with clr_idx=6 changes nothing.
- Assert reset during an active event stream with rd_req pending. The cycle after reset, rd_rsp_valid=0 and every counter reads 0.
